// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract with parametrised field widths.
// Operand capture, then unpack/align, add/sub, normalise/round/pack.
// Denormal inputs and underflowing results are flushed to signed zero.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] in1,
    input  logic [EXP_W+MAN_W:0] in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out,
    output logic                 overflow,
    output logic                 invalid
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int AW  = MAN_W + 5;          // SW plus carry-out
    localparam int LZW = $clog2(AW) + 1;
    localparam int XW  = EXP_W + LZW + 1;    // signed working exponent
    localparam logic signed [XW-1:0] X_EMAX = XW'((2 ** EXP_W) - 1);

    // Handshake: an operand transfers on in_valid & in_ready, a result on
    // out_valid & out_ready; while a result waits (out_valid & ~out_ready)
    // every stage holds, so in_ready is simply the inverse of that stall.
    logic w_stall;
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // ---------------- operand capture ----------------
    logic         r0_valid;
    logic [W-1:0] r0_a;
    logic [W-1:0] r0_b;
    logic         r0_sub;

    // Capture operands and op whenever the pipe advances
    always_ff @(posedge clk) begin
        if (reset) r0_valid <= 1'b0;
        else if (!w_stall) r0_valid <= in_valid;
        if (!w_stall) begin
            r0_a   <= in1;
            r0_b   <= in2;
            r0_sub <= op_sub;
        end
    end

    // ---------------- stage 1: unpack / classify / align ----------------
    logic                   w_sa, w_sb;
    logic [EXP_W-1:0]       w_ea, w_eb;
    logic [MAN_W-1:0]       w_fa, w_fb;
    logic                   w_a_zero, w_b_zero, w_a_spec, w_b_spec;
    logic                   w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
    logic [SW-1:0]          w_sig_a, w_sig_b, w_sig_big, w_sig_small;
    logic [SW-1:0]          w_shifted, w_aligned;
    logic                   w_lost, w_swap, w_s_big;
    logic [EXP_W-1:0]       w_e_big, w_e_small, w_diff;

    assign w_sa     = r0_a[W-1];
    assign w_sb     = r0_b[W-1] ^ r0_sub;
    assign w_ea     = r0_a[W-2:MAN_W];
    assign w_eb     = r0_b[W-2:MAN_W];
    assign w_fa     = r0_a[MAN_W-1:0];
    assign w_fb     = r0_b[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_spec = (w_ea == '1);
    assign w_b_spec = (w_eb == '1);
    assign w_a_nan  = w_a_spec & (|w_fa);
    assign w_b_nan  = w_b_spec & (|w_fb);
    assign w_a_inf  = w_a_spec & ~(|w_fa);
    assign w_b_inf  = w_b_spec & ~(|w_fb);

    // Zero-exponent operands are treated as exact zeros everywhere below
    assign w_mag_a = w_a_zero ? '0 : {w_ea, w_fa};
    assign w_mag_b = w_b_zero ? '0 : {w_eb, w_fb};
    assign w_sig_a = {~w_a_zero, (w_a_zero ? {MAN_W{1'b0}} : w_fa), 3'b000};
    assign w_sig_b = {~w_b_zero, (w_b_zero ? {MAN_W{1'b0}} : w_fb), 3'b000};

    assign w_swap      = (w_mag_b > w_mag_a);
    assign w_s_big     = w_swap ? w_sb : w_sa;
    assign w_e_big     = w_swap ? w_eb : w_ea;
    assign w_e_small   = w_swap ? w_ea : w_eb;
    assign w_sig_big   = w_swap ? w_sig_b : w_sig_a;
    assign w_sig_small = w_swap ? w_sig_a : w_sig_b;
    assign w_diff      = w_e_big - w_e_small;
    assign w_shifted   = w_sig_small >> w_diff;
    assign w_lost      = |(w_sig_small & ~({SW{1'b1}} << w_diff));

    // Align the smaller significand; bits shifted out collapse into sticky
    always_comb begin
        if (int'(w_diff) >= MAN_W + 3) w_aligned = {{(SW-1){1'b0}}, |w_sig_small};
        else                           w_aligned = w_shifted | {{(SW-1){1'b0}}, w_lost};
    end

    logic             r1_valid, r1_sign, r1_eff_sub;
    logic [EXP_W-1:0] r1_exp;
    logic [SW-1:0]    r1_sig_big, r1_sig_small;
    logic             r1_invalid, r1_inf, r1_inf_sign, r1_neg_zero;

    // Register aligned operands and the special-case classification
    always_ff @(posedge clk) begin
        if (reset) r1_valid <= 1'b0;
        else if (!w_stall) r1_valid <= r0_valid;
        if (!w_stall) begin
            r1_sign      <= w_s_big;
            r1_eff_sub   <= w_sa ^ w_sb;
            r1_exp       <= w_e_big;
            r1_sig_big   <= w_sig_big;
            r1_sig_small <= w_aligned;
            r1_invalid   <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
            r1_inf       <= w_a_inf | w_b_inf;
            r1_inf_sign  <= w_a_inf ? w_sa : w_sb;
            r1_neg_zero  <= w_a_zero & w_b_zero & w_sa & w_sb;
        end
    end

    // ---------------- stage 2: significand add / subtract ----------------
    logic [AW-1:0] w_sum;
    assign w_sum = r1_eff_sub ? ({1'b0, r1_sig_big} - {1'b0, r1_sig_small})
                              : ({1'b0, r1_sig_big} + {1'b0, r1_sig_small});

    logic             r2_valid, r2_sign;
    logic [EXP_W-1:0] r2_exp;
    logic [AW-1:0]    r2_sum;
    logic             r2_invalid, r2_inf, r2_inf_sign, r2_neg_zero;

    // Register the raw sum; the larger magnitude always sets the sign
    always_ff @(posedge clk) begin
        if (reset) r2_valid <= 1'b0;
        else if (!w_stall) r2_valid <= r1_valid;
        if (!w_stall) begin
            r2_sign     <= r1_sign;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
            r2_invalid  <= r1_invalid;
            r2_inf      <= r1_inf;
            r2_inf_sign <= r1_inf_sign;
            r2_neg_zero <= r1_neg_zero;
        end
    end

    // ---------------- stage 3: normalise / round / pack ----------------
    function automatic logic [LZW-1:0] lzc_f(input logic [SW-1:0] v);
        lzc_f = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc_f = LZW'(SW - 1 - i);
    endfunction

    logic [LZW-1:0]          w_lzc;
    logic signed [XW-1:0]    w_exp_x, w_exp_n, w_exp_f;
    logic [SW-1:0]           w_norm;
    logic                    w_round_up;
    logic [MAN_W+1:0]        w_mant_r;
    logic [MAN_W-1:0]        w_frac;
    logic [W-1:0]            w_res;
    logic                    w_ovf, w_inv;

    assign w_lzc   = lzc_f(r2_sum[SW-1:0]);
    assign w_exp_x = $signed({{(XW-EXP_W){1'b0}}, r2_exp});

    // Normalise, round to nearest even, then apply special-case priority
    always_comb begin
        if (r2_sum[AW-1]) begin
            w_norm  = r2_sum[AW-1:1] | {{(SW-1){1'b0}}, r2_sum[0]};
            w_exp_n = w_exp_x + $signed({{(XW-1){1'b0}}, 1'b1});
        end else begin
            w_norm  = r2_sum[SW-1:0] << w_lzc;
            w_exp_n = w_exp_x - $signed({{(XW-LZW){1'b0}}, w_lzc});
        end
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant_r   = {1'b0, w_norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
        w_frac     = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
        w_exp_f    = w_exp_n + $signed({{(XW-1){1'b0}}, w_mant_r[MAN_W+1]});

        w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_frac};
        w_ovf = 1'b0;
        w_inv = 1'b0;
        if (r2_invalid) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_inv = 1'b1;
        end else if (r2_inf) begin
            w_res = {r2_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
        end else if (r2_sum == '0) begin
            w_res = {r2_neg_zero, {(EXP_W+MAN_W){1'b0}}};
        end else if (w_exp_f >= X_EMAX) begin
            w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
        end else if (w_exp_f[XW-1] || (w_exp_f == '0)) begin
            w_res = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // Output register; holds result and flags steady while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
        end else if (!w_stall) begin
            out_valid <= r2_valid;
            out       <= w_res;
            overflow  <= w_ovf;
            invalid   <= w_inv;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed vectors, exact-arithmetic reference,
// in-order scoreboard, backpressure, reset flush and a half-precision instance.
module tb_fp_addsub_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, op_sub, out_valid, out_ready, overflow, invalid;
    logic [31:0] in1, in2, out;

    logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready, h_overflow, h_invalid;
    logic [15:0] h_in1, h_in2, h_out;

    fp_addsub_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .in1(in1), .in2(in2), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .overflow(overflow), .invalid(invalid)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op_sub(h_op_sub), .in1(h_in1), .in2(h_in2), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .out(h_out), .overflow(h_overflow), .invalid(h_invalid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [33:0] exp_q[$];   // {result, overflow, invalid}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- reference: exact sum, then round-to-nearest-even ----------------
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic         sa, sb, sn;
        int           ea, eb, emin, p, k, e;
        logic [319:0] ma, mb, x, y, s, q, rem, half;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255 && sa != sb))
            return {32'h7FC00000, 2'b01};
        if (ea == 255) return {sa, 8'hFF, 23'h0, 2'b10};
        if (eb == 255) return {sb, 8'hFF, 23'h0, 2'b10};
        ma = (ea == 0) ? 320'd0 : 320'({1'b1, a[22:0]});
        mb = (eb == 0) ? 320'd0 : 320'({1'b1, b[22:0]});
        if (ma == 0 && mb == 0) return {sa & sb, 31'h0, 2'b00};
        if (ma == 0)      emin = eb;
        else if (mb == 0) emin = ea;
        else              emin = (ea < eb) ? ea : eb;
        x = (ma == 0) ? 320'd0 : (ma << (ea - emin));
        y = (mb == 0) ? 320'd0 : (mb << (eb - emin));
        if (sa == sb)    begin s = x + y; sn = sa; end
        else if (x >= y) begin s = x - y; sn = sa; end
        else             begin s = y - x; sn = sb; end
        if (s == 0) return 34'h0;
        p = 0;
        for (int i = 0; i < 320; i++) if (s[i]) p = i;
        e = p + emin - 23;
        if (p > 23) begin
            k    = p - 23;
            q    = s >> k;
            rem  = s & ((320'd1 << k) - 320'd1);
            half = 320'd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 320'd1;
            if (q[24]) begin q = q >> 1; e++; end
        end else begin
            q = s << (23 - p);
        end
        if (e >= 255) return {sn, 8'hFF, 23'h0, 2'b10};
        if (e <= 0)   return {sn, 31'h0, 2'b00};
        return {sn, e[7:0], q[22:0], 2'b00};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] lit, input logic lit_ovf, input logic lit_inv);
        logic [33:0] m;
        int guard;
        m = model(a, b, s);
        check("model_vs_hand", m, {lit, lit_ovf, lit_inv});
        in1 = a; in2 = b; op_sub = s; in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("accept_in_time", in_ready, 1'b1);
        exp_q.push_back(m);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("drain_done", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("idle_after_drain", out_valid, 1'b0);
    endtask

    task automatic half_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] res, input logic ovf);
        int cyc;
        h_in1 = a; h_in2 = b; h_op_sub = 1'b0; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        cyc = 0;
        while (!h_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("half_latency", cyc, 4);
        check("half_out", h_out, res);
        check("half_ovf", h_overflow, ovf);
        check("half_inv", h_invalid, 1'b0);
        @(posedge clk); #1;
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic        hold_vld = 1'b0;
    logic [33:0] hold_val;

    always @(negedge clk) begin
        if (reset) begin
            hold_vld = 1'b0;
        end else begin
            if (out_valid && hold_vld)
                check("stall_hold", {out, overflow, invalid}, hold_val);
            if (out_valid && out_ready) begin
                check("result_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    check("result", {out, overflow, invalid}, exp_q.pop_front());
                hold_vld = 1'b0;
            end else if (out_valid) begin
                hold_vld = 1'b1;
                hold_val = {out, overflow, invalid};
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; in_valid = 1'b0; op_sub = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_op_sub = 1'b0; h_in1 = '0; h_in2 = '0; h_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 32'h0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_invalid", invalid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);

        // Latency: accept at edge N, out_valid visible only after edge N+3
        @(posedge clk); #1;
        check("model_vs_hand", model(32'hFF800000, 32'hBF800000, 1'b0), {32'hFF800000, 2'b10});
        exp_q.push_back(model(32'hFF800000, 32'hBF800000, 1'b0));
        in1 = 32'hFF800000; in2 = 32'hBF800000; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("latency_out_valid", out_valid, (i == 3));
        end
        wait_drain();

        // Directed vectors, issued back to back
        @(posedge clk); #1;
        send(32'h3FC00000, 32'hC0B00000, 1'b0, 32'hC0800000, 1'b0, 1'b0);
        send(32'h40700000, 32'h3FA00000, 1'b1, 32'h40200000, 1'b0, 1'b0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
        send(32'h00000000, 32'h3F99999A, 1'b0, 32'h3F99999A, 1'b0, 1'b0);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0);
        send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
        send(32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
        send(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, 1'b0);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        send(32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 1'b0, 1'b0);
        send(32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
        send(32'h7F800000, 32'hBF800000, 1'b1, 32'h7F800000, 1'b1, 1'b0);
        send(32'hC0000000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        wait_drain();

        // Backpressure: four ops queue up behind a stalled consumer
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0);
        send(32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 1'b0, 1'b0);
        send(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_in_ready_low", in_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("bp_queue_intact", exp_q.size(), 4);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset with two ops in flight: nothing stale may emerge
        @(posedge clk); #1;
        in1 = 32'h3F800000; in2 = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in1 = 32'h40000000; in2 = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_no_stale", out_valid, 1'b0);
        end

        // Half-precision instance
        @(posedge clk); #1;
        half_op(16'h3C00, 16'h3C00, 16'h4000, 1'b0);
        half_op(16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
